rr_tdm_demux_acc: RTL and testbench
===================================

RR_TDM_DEMUX_ACC -- requirements
Module: rr_tdm_demux_acc

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 16, as the width of the interleaved TDM product stream.
REQ-002 The block SHALL take parameter NUM_CH, default 2, as the number of interleaved channels; legal range is 2..8.
REQ-003 The block SHALL take parameter ACC_LEN, default 4, as the number of samples per channel per accumulation window; legal values are powers of two from 2 to 256.
REQ-004 The block SHALL take parameter FIFO_DEPTH, default 4, as the number of result-FIFO entries; legal values are powers of two from 2 upward.
REQ-005 clk  input  1  sole clock; one clock, all logic on the rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 din  input  DATA_WIDTH  TDM sample, unsigned.
REQ-008 din_valid  input  1  din is qualified this cycle.
REQ-009 din_sof  input  1  frame marker, meaningful only with din_valid; when set, din belongs to channel 0 and is the first sample of a new window.
REQ-010 dout_sum  output  ACC_W  window sum, where ACC_W = DATA_WIDTH + log2(ACC_LEN).
REQ-011 dout_ch  output  CH_W  channel index of dout_sum, where CH_W = max(1, clog2(NUM_CH)).
REQ-012 dout_valid/dout_ready  output/input  1/1  result handshake; a transfer occurs when both are high.
REQ-013 sync_err  output  1  one-cycle pulse when din_sof arrives at an unexpected position.
REQ-014 overflow  output  1  sticky flag set when a result is dropped.

Function
REQ-015 The FSM SHALL have two states, UNSYNC and RUN, and SHALL leave reset in UNSYNC.
REQ-016 In UNSYNC, the block SHALL ignore every din_valid beat without din_sof.
REQ-017 A din_valid beat with din_sof SHALL move the FSM to RUN, set ch_idx=0 and frame_cnt=0, and load acc[0]=din.
REQ-018 In RUN, each din_valid beat SHALL be assigned to channel ch_idx, after which ch_idx SHALL advance and wrap from NUM_CH-1 to 0.
REQ-019 frame_cnt SHALL increment on each wrap of ch_idx and SHALL wrap from ACC_LEN-1 to 0.
REQ-020 When frame_cnt==0, the beat SHALL load acc[ch]=din; otherwise it SHALL set acc[ch]+=din.
REQ-021 Accumulation SHALL be full-width at ACC_W bits and SHALL never saturate or wrap.
REQ-022 When frame_cnt==ACC_LEN-1, the beat SHALL complete a window and SHALL push {ch, acc[ch]+din} into the FIFO on the same edge.
REQ-023 A window completion SHALL therefore produce NUM_CH consecutive pushes, one per valid beat.
REQ-024 When din_sof arrives in RUN with ch_idx!=0 or frame_cnt!=0, the block SHALL pulse sync_err, discard all partial sums, and resynchronise exactly as in REQ-017.
REQ-025 When din_sof arrives at the expected position, the block SHALL produce no sync_err pulse.
REQ-026 When din_valid is low, the block SHALL hold all state; gaps between beats are legal.
REQ-027 The FIFO SHALL be first-word fall-through.
REQ-028 A result pushed on edge N SHALL appear with dout_valid high after edge N, giving latency 1 cycle from the final sample beat.
REQ-029 dout_sum and dout_ch SHALL be stable while dout_valid is high and dout_ready is low.
REQ-030 A push into a full FIFO without a pop on the same cycle SHALL be dropped and SHALL set overflow; the FIFO contents SHALL remain unchanged.
REQ-031 A push and a pop on the same cycle while the FIFO is full SHALL both succeed, leaving the occupancy unchanged.
REQ-032 A push and a pop on the same cycle while the FIFO is empty SHALL make the data visible on the next cycle.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an extra wrap bit for full/empty discrimination.

Reset
REQ-034 Asserting rst SHALL asynchronously force state=UNSYNC, ch_idx=0, frame_cnt=0, and all FIFO pointers to 0.
REQ-035 Asserting rst SHALL asynchronously force dout_valid=0, sync_err=0 and overflow=0, regardless of any operation in progress.
REQ-036 Accumulator and FIFO storage SHALL carry no reset requirement, because they are never observable before being written.
REQ-037 rst deassertion SHALL be synchronised externally; the block SHALL assume no ordering between rst deassertion and din_valid.

Structure
REQ-038 A shared package SHALL hold the FSM state enum, the result struct {ch, sum}, and helper functions for ACC_W and CH_W.
REQ-039 The result FIFO SHALL be one sub-module named sync_fifo_fwft, parameterised by width and depth, with the same clk/rst ports.
REQ-040 The top level SHALL contain the FSM, the counters and the NUM_CH-entry accumulator array.

Verification
REQ-041 With sof on the first beat, ch0 samples 1,2,3,4 and ch1 samples 10,20,30,40 interleaved, and dout_ready=1, the bench SHALL observe (ch0, 10) and then (ch1, 100) on consecutive cycles, with no sync_err.
REQ-042 With all beats 0xFFFF for one window, the bench SHALL observe dout_sum=0x3FFFC for both channels.
REQ-043 With dout_ready=0 for 3 windows, which produces 6 pushes, the bench SHALL observe overflow=1 and, after ready is raised, exactly the first 4 results in order, then dout_valid=0.
REQ-044 With sof injected at ch_idx=1, frame_cnt=2, the bench SHALL observe a one-cycle sync_err, no result from the partial window, and a correct first window afterward.
REQ-045 With beats before any sof, the bench SHALL observe no outputs; with rst asserted mid-window, outputs SHALL clear within the same cycle and the block SHALL require a new sof.
REQ-046 With random din_valid gaps and dout_ready toggling, a bench scoreboard SHALL observe every result matching the reference model with none lost while overflow=0.

Source files
------------

// File: rtl/rr_tdm_demux_acc_pkg.sv
// rr_tdm_demux_acc_pkg: shared FSM state type and width helpers for the TDM demux accumulator
package rr_tdm_demux_acc_pkg;
  typedef enum logic {UNSYNC, RUN} state_t;
  function automatic int acc_w(input int dw, input int len);
    return dw + $clog2(len);
  endfunction
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO; push/push_data in, pop/pop_data/valid out, sticky overflow on dropped push
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic empty, full, do_pop, do_push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign valid = !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_push) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/rr_tdm_demux_acc.sv
// rr_tdm_demux_acc: round-robin TDM demux with per-channel window accumulation; din/din_valid/din_sof in, dout_sum/dout_ch valid-ready out, sync_err pulse, sticky overflow
module rr_tdm_demux_acc
  import rr_tdm_demux_acc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH = 2,
  parameter int ACC_LEN = 4,
  parameter int FIFO_DEPTH = 4,
  localparam int ACC_W = acc_w(DATA_WIDTH, ACC_LEN),
  localparam int CH_W = ch_w(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  input  logic                  din_sof,
  output logic [ACC_W-1:0]      dout_sum,
  output logic [CH_W-1:0]       dout_ch,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  sync_err,
  output logic                  overflow
);
  localparam int FC_W = $clog2(ACC_LEN);
  state_t state, state_nx;
  logic [CH_W-1:0] ch_idx, cur_ch;
  logic [FC_W-1:0] frame_cnt, cur_fc;
  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] sum;
  logic take, last_ch, push;
  assign take = din_valid && (state == RUN || din_sof);
  assign cur_ch = din_sof ? '0 : ch_idx;
  assign cur_fc = din_sof ? '0 : frame_cnt;
  assign sum = (cur_fc == '0 ? '0 : acc[cur_ch]) + ACC_W'(din);
  assign last_ch = cur_ch == CH_W'(NUM_CH - 1);
  assign push = take && cur_fc == FC_W'(ACC_LEN - 1);
  always_comb begin
    state_nx = (din_valid && din_sof) ? RUN : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= UNSYNC;
      ch_idx <= '0;
      frame_cnt <= '0;
      sync_err <= 1'b0;
    end else begin
      state <= state_nx;
      sync_err <= din_valid && din_sof && state == RUN && (ch_idx != '0 || frame_cnt != '0);
      if (take) begin
        ch_idx <= last_ch ? '0 : cur_ch + 1'b1;
        frame_cnt <= last_ch ? cur_fc + 1'b1 : cur_fc;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (take) acc[cur_ch] <= sum;
  end
  sync_fifo_fwft #(.WIDTH(CH_W + ACC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_data({cur_ch, sum}),
    .pop(dout_ready),
    .pop_data({dout_ch, dout_sum}),
    .valid(dout_valid),
    .overflow(overflow)
  );
endmodule

// File: tb/tb_rr_tdm_demux_acc.sv
// tb_rr_tdm_demux_acc: directed and random checks of rr_tdm_demux_acc against a positional window-sum model
module tb_rr_tdm_demux_acc;
  import rr_tdm_demux_acc_pkg::*;
  localparam int DATA_WIDTH = 16;
  localparam int NUM_CH = 2;
  localparam int ACC_LEN = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int ACC_W = acc_w(DATA_WIDTH, ACC_LEN);
  localparam int CH_W = ch_w(NUM_CH);
  typedef struct {int ch; longint sum; int cyc;} res_t;
  logic clk = 1'b0;
  logic rst;
  logic [DATA_WIDTH-1:0] din;
  logic din_valid, din_sof, dout_ready;
  logic [ACC_W-1:0] dout_sum;
  logic [CH_W-1:0] dout_ch;
  logic dout_valid, sync_err, overflow;
  int n_cmp = 0, n_bad = 0, cyc = 0, serr_cnt = 0, n_push = 0;
  res_t q[$], log[$];
  longint wsum [NUM_CH];
  bit synced = 0, exp_serr = 0, exp_ovf = 0;
  int pos = 0;
  always #5 clk = ~clk;
  rr_tdm_demux_acc #(.DATA_WIDTH(DATA_WIDTH), .NUM_CH(NUM_CH), .ACC_LEN(ACC_LEN), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .din_valid(din_valid),
    .din_sof(din_sof),
    .dout_sum(dout_sum),
    .dout_ch(dout_ch),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .sync_err(sync_err),
    .overflow(overflow)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_edge(input logic v, input logic s, input logic [DATA_WIDTH-1:0] d, input logic r);
    int c, f;
    exp_serr = 0;
    if (r && q.size() != 0) q.delete(0);
    if (v) begin
      if (s) begin
        if (synced && pos != 0) exp_serr = 1;
        synced = 1;
        pos = 0;
      end
      if (synced) begin
        c = pos % NUM_CH;
        f = (pos / NUM_CH) % ACC_LEN;
        wsum[c] = (f == 0) ? longint'(d) : wsum[c] + longint'(d);
        if (f == ACC_LEN - 1) begin
          if (q.size() < FIFO_DEPTH) begin
            q.push_back('{c, wsum[c], 0});
            n_push++;
          end else exp_ovf = 1;
        end
        pos = (pos + 1) % (NUM_CH * ACC_LEN);
      end
    end
  endtask
  task automatic cycle(input logic v, input logic s, input logic [DATA_WIDTH-1:0] d, input logic r);
    din_valid = v;
    din_sof = s;
    din = d;
    dout_ready = r;
    @(negedge clk);
    check("dout_valid", dout_valid, q.size() != 0);
    if (q.size() != 0 && dout_valid) begin
      check("dout_ch", dout_ch, q[0].ch);
      check("dout_sum", dout_sum, q[0].sum);
    end
    check("sync_err", sync_err, exp_serr);
    check("overflow", overflow, exp_ovf);
    if (dout_valid && r) log.push_back('{int'(dout_ch), longint'(dout_sum), cyc});
    if (sync_err) serr_cnt++;
    model_edge(v, s, d, r);
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", dout_valid, 0);
    check("rst_sync_err", sync_err, 0);
    check("rst_overflow", overflow, 0);
    q.delete();
    synced = 0;
    pos = 0;
    exp_serr = 0;
    exp_ovf = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [DATA_WIDTH-1:0] seq [8];
    logic v, s, r;
    din = '0;
    din_valid = 0;
    din_sof = 0;
    dout_ready = 0;
    do_reset();
    cycle(0, 0, 0, 1);
    // basic interleave
    seq = '{1, 10, 2, 20, 3, 30, 4, 40};
    log.delete();
    serr_cnt = 0;
    for (int i = 0; i < 8; i++) cycle(1, i == 0, seq[i], 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    check("t1_count", log.size(), 2);
    if (log.size() >= 2) begin
      check("t1_ch0", log[0].ch, 0);
      check("t1_sum0", log[0].sum, 10);
      check("t1_ch1", log[1].ch, 1);
      check("t1_sum1", log[1].sum, 100);
      check("t1_consec", log[1].cyc - log[0].cyc, 1);
    end
    check("t1_serr", serr_cnt, 0);
    // full-scale samples
    log.delete();
    for (int i = 0; i < 8; i++) cycle(1, i == 0, 16'hFFFF, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    check("t2_count", log.size(), 2);
    foreach (log[i]) check("t2_sum", log[i].sum, 64'h3FFFC);
    // overflow with ready held low
    do_reset();
    log.delete();
    for (int i = 0; i < 24; i++) cycle(1, i == 0, DATA_WIDTH'($urandom_range(0, 16'hFFFF)), 0);
    check("t3_overflow", overflow, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 1);
    check("t3_count", log.size(), 4);
    foreach (log[i]) check("t3_order", log[i].ch, i % NUM_CH);
    check("t3_drained", dout_valid, 0);
    // misplaced sof at ch_idx=1, frame_cnt=2
    do_reset();
    log.delete();
    serr_cnt = 0;
    for (int i = 0; i < 5; i++) cycle(1, i == 0, 100, 1);
    seq = '{5, 6, 7, 8, 9, 10, 11, 12};
    for (int i = 0; i < 8; i++) cycle(1, i == 0, seq[i], 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    check("t4_serr_pulses", serr_cnt, 1);
    check("t4_count", log.size(), 2);
    if (log.size() >= 2) begin
      check("t4_sum0", log[0].sum, 32);
      check("t4_sum1", log[1].sum, 36);
    end
    // pre-sync beats and mid-window reset
    do_reset();
    log.delete();
    for (int i = 0; i < 10; i++) cycle(1, 0, 16'h1234, 1);
    check("t5_presync", log.size(), 0);
    for (int i = 0; i < 27; i++) cycle(1, i == 0, DATA_WIDTH'(i + 1), 0);
    check("t5_pre_rst_valid", dout_valid, 1);
    check("t5_pre_rst_ovf", overflow, 1);
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1, 0, 16'h00FF, 1);
    check("t5_needs_sof", log.size(), 0);
    // random traffic
    do_reset();
    log.delete();
    n_push = 0;
    for (int i = 0; i < 4000; i++) begin
      v = $urandom_range(0, 9) < 7;
      s = v && (!synced || (pos == 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0);
      r = $urandom_range(0, 9) < 6;
      cycle(v, s, DATA_WIDTH'($urandom_range(0, 16'hFFFF)), r);
    end
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1);
    if (!exp_ovf) check("rand_lost", log.size(), n_push);
    check("rand_drained", dout_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
